ising_observable_reader: RTL and testbench

- Sequential readout engine for the Ising lattice core. On a strobe it snapshots the N×N spin lattice and computes energy and magnetization one row per cycle.
- Results are emitted as a single record on a valid/ready stream toward the host or CSR/UART bridge.
- It is the consuming end of the lattice-state interface and replaces per-sweep simulation-only printing with synthesizable readout.

---
 rtl/ising_pkg.sv | 20 ++
 rtl/ising_row_stats.sv | 33 +++
 rtl/ising_observable_reader.sv | 140 ++++++++++++++
 tb/tb_ising_observable_reader.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// Shared lattice constants, readout FSM states and the stored-bit spin convention
// used by the Ising observable reader.
package ising_pkg;

    localparam int N   = 32;
    localparam int E_W = $clog2(4 * N * N) + 2;
    localparam int M_W = $clog2(N * N) + 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } state_t;

    // A stored 1 is spin +1, a stored 0 is spin -1.
    function automatic logic signed [1:0] spin_value(input logic s);
        return s ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/ising_row_stats.sv
// Combinational energy and magnetization contribution of one lattice row,
// given the rows above and below it on the torus.
module ising_row_stats #(
    parameter int N    = 32,
    parameter int RE_W = $clog2(4 * N) + 2,
    parameter int RM_W = $clog2(N) + 2
) (
    input  logic [N-1:0]           above,
    input  logic [N-1:0]           current,
    input  logic [N-1:0]           below,
    output logic signed [RE_W-1:0] row_energy,
    output logic signed [RM_W-1:0] row_mag
);

    logic [N-1:0] west_nb;
    logic [N-1:0] east_nb;
    int           disagree;
    int           ups;

    assign west_nb = {current[N-2:0], current[N-1]};
    assign east_nb = {current[0], current[N-1:1]};

    // A site with d disagreeing neighbours contributes -(4 - 2d) = 2d - 4,
    // so the row energy only needs the total disagreement count.
    always_comb begin
        disagree   = $countones(current ^ above) + $countones(current ^ below)
                   + $countones(current ^ west_nb) + $countones(current ^ east_nb);
        ups        = $countones(current);
        row_energy = RE_W'(2 * disagree - 4 * N);
        row_mag    = RM_W'(2 * ups - N);
    end

endmodule

// File: rtl/ising_observable_reader.sv
// Snapshot-based energy/magnetization readout of the Ising lattice, one row per cycle.
// Defining ISING_DROP_CNT_EN adds a saturating counter of strobes ignored while busy.
module ising_observable_reader #(
    parameter int N       = ising_pkg::N,
    parameter int SWEEP_W = 32,
    parameter int E_W     = $clog2(4 * N * N) + 2,
    parameter int M_W     = $clog2(N * N) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  snap_strobe,
    input  logic [N*N-1:0]        lattice,
    input  logic [SWEEP_W-1:0]    sweep_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SWEEP_W-1:0]    out_sweep,
    output logic signed [E_W-1:0] out_energy,
    output logic signed [M_W-1:0] out_mag
`ifdef ISING_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    import ising_pkg::*;

    localparam int RW   = $clog2(N);
    localparam int RE_W = $clog2(4 * N) + 2;
    localparam int RM_W = $clog2(N) + 2;

    state_t                 state;
    state_t                 state_next;
    logic [N*N-1:0]         snapshot;
    logic [N-1:0]           snap_rows [N];
    logic [RW-1:0]          row;
    logic [RW-1:0]          row_above;
    logic [RW-1:0]          row_below;
    logic [SWEEP_W-1:0]     sweep_reg;
    logic signed [E_W-1:0]  energy_acc;
    logic signed [E_W-1:0]  energy_sum;
    logic signed [M_W-1:0]  mag_acc;
    logic signed [M_W-1:0]  mag_sum;
    logic signed [RE_W-1:0] row_energy;
    logic signed [RM_W-1:0] row_mag;
    logic                   last_row;

    for (genvar k = 0; k < N; k++) begin : g_rows
        assign snap_rows[k] = snapshot[k*N +: N];
    end

    // N is a power of two, so plain modular row arithmetic gives the torus wrap.
    assign row_above = row - RW'(1);
    assign row_below = row + RW'(1);
    assign last_row  = (row == RW'(N - 1));

    ising_row_stats #(
        .N    (N),
        .RE_W (RE_W),
        .RM_W (RM_W)
    ) u_row_stats (
        .above      (snap_rows[row_above]),
        .current    (snap_rows[row]),
        .below      (snap_rows[row_below]),
        .row_energy (row_energy),
        .row_mag    (row_mag)
    );

    assign energy_sum = energy_acc + E_W'(row_energy);
    assign mag_sum    = mag_acc + M_W'(row_mag);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == EMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (snap_strobe) state_next = ACCUM;
            ACCUM:   if (last_row) state_next = EMIT;
            EMIT:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs load only when the last row lands, so they hold steady through
    // EMIT and keep the previous record after the transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot   <= '0;
            sweep_reg  <= '0;
            row        <= '0;
            energy_acc <= '0;
            mag_acc    <= '0;
            out_sweep  <= '0;
            out_energy <= '0;
            out_mag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (snap_strobe) begin
                        snapshot   <= lattice;
                        sweep_reg  <= sweep_in;
                        row        <= '0;
                        energy_acc <= '0;
                        mag_acc    <= '0;
                    end
                end
                ACCUM: begin
                    energy_acc <= energy_sum;
                    mag_acc    <= mag_sum;
                    row        <= row + RW'(1);
                    if (last_row) begin
                        out_energy <= energy_sum;
                        out_mag    <= mag_sum;
                        out_sweep  <= sweep_reg;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ISING_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (snap_strobe && busy && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ising_observable_reader.sv
// Scoreboard bench for ising_observable_reader; honours ISING_DROP_CNT_EN when defined.
module tb_ising_observable_reader;

    localparam int N  = 32;
    localparam int SW = 32;
    localparam int EW = $clog2(4 * N * N) + 2;
    localparam int MW = $clog2(N * N) + 2;

    typedef struct {
        int            energy;
        int            mag;
        logic [SW-1:0] sweep;
    } rec_t;

    logic                 clk;
    logic                 reset;
    logic                 snap_strobe;
    logic [N*N-1:0]       lattice;
    logic [SW-1:0]        sweep_in;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        out_sweep;
    logic signed [EW-1:0] out_energy;
    logic signed [MW-1:0] out_mag;
`ifdef ISING_DROP_CNT_EN
    logic [15:0]          drop_cnt;
`endif

    rec_t sb[$];
    rec_t exp_rec;
    int   checks;
    int   errors;
    int   transfers;

    ising_observable_reader #(
        .N       (N),
        .SWEEP_W (SW),
        .E_W     (EW),
        .M_W     (MW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .snap_strobe (snap_strobe),
        .lattice     (lattice),
        .sweep_in    (sweep_in),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sweep   (out_sweep),
        .out_energy  (out_energy),
        .out_mag     (out_mag)
`ifdef ISING_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int spin(input logic [N*N-1:0] lat, input int k, input int l);
        logic [N*N-1:0] t;
        t = lat >> (((k + N) % N) * N + ((l + N) % N));
        return int'(ising_pkg::spin_value(t[0]));
    endfunction

    // Reference by direct neighbour products on the torus.
    task automatic model(input logic [N*N-1:0] lat, output int e, output int m);
        int s;
        int nb;
        e = 0;
        m = 0;
        for (int k = 0; k < N; k++) begin
            for (int l = 0; l < N; l++) begin
                s  = spin(lat, k, l);
                nb = spin(lat, k - 1, l) + spin(lat, k + 1, l) + spin(lat, k, l - 1) + spin(lat, k, l + 1);
                e  = e - s * nb;
                m  = m + s;
            end
        end
    endtask

    function automatic logic [N*N-1:0] rand_lattice();
        logic [N*N-1:0] v;
        v = '0;
        for (int i = 0; i < (N * N) / 32; i++) begin
            v = (v << 32) | (N*N)'($urandom);
        end
        return v;
    endfunction

    function automatic logic [N*N-1:0] checker_lattice();
        logic [N*N-1:0] v;
        logic [N*N-1:0] one;
        v      = '0;
        one    = '0;
        one[0] = 1'b1;
        for (int k = 0; k < N; k++) begin
            for (int l = 0; l < N; l++) begin
                if (((k + l) % 2) == 1) v = v | (one << (k * N + l));
            end
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_strobe(input logic [N*N-1:0] lat, input logic [SW-1:0] sw,
                                input int e, input int m);
        rec_t r;
        r.energy    = e;
        r.mag       = m;
        r.sweep     = sw;
        lattice     = lat;
        sweep_in    = sw;
        snap_strobe = 1'b1;
        sb.push_back(r);
    endtask

    task automatic wait_transfers(input int target, input int budget, output bit ok);
        for (int t = 0; t < budget; t++) begin
            if (transfers >= target) break;
            step();
        end
        ok = (transfers >= target);
    endtask

    // Scoreboard: a record is compared on the cycle its handshake completes.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            transfers = transfers + 1;
            checks    = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL record_unexpected got energy=%0d mag=%0d sweep=%h, none expected",
                         out_energy, out_mag, out_sweep);
            end else begin
                exp_rec = sb.pop_front();
                if (int'(out_energy) !== exp_rec.energy || int'(out_mag) !== exp_rec.mag ||
                    out_sweep !== exp_rec.sweep) begin
                    errors = errors + 1;
                    $display("[TB] FAIL record got energy=%0d mag=%0d sweep=%h, expected energy=%0d mag=%0d sweep=%h",
                             out_energy, out_mag, out_sweep, exp_rec.energy, exp_rec.mag, exp_rec.sweep);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_sweep !== '0 || out_energy !== '0 || out_mag !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got busy=%b valid=%b sweep=%h energy=%0d mag=%0d, expected all zero",
                     busy, out_valid, out_sweep, out_energy, out_mag);
        end
`ifdef ISING_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_drop_cnt got %0d expected 0", drop_cnt);
        end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_all_ones();
        int  lat_cycles;
        bit  ok;
        int  target;
        out_ready = 1'b1;
        target    = transfers + 1;
        drive_strobe({(N*N){1'b1}}, 32'h1234_0001, -4096, 1024);
        step();
        snap_strobe = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_after_strobe got %b expected 1", busy);
        end
        lat_cycles = 0;
        @(negedge clk);
        while (!out_valid && lat_cycles < 4 * N) begin
            lat_cycles++;
            @(negedge clk);
        end
        checks++;
        if (lat_cycles != N) begin
            errors++;
            $display("[TB] FAIL latency got %0d cycles expected %0d", lat_cycles, N);
        end
        step();
        wait_transfers(target, 4 * N, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL all_ones_transfer got %0d transfers expected %0d", transfers, target);
        end
    endtask

    task automatic test_pattern(input logic [N*N-1:0] lat, input logic [SW-1:0] sw,
                                input int e, input int m);
        bit ok;
        int target;
        out_ready = 1'b1;
        target    = transfers + 1;
        drive_strobe(lat, sw, e, m);
        step();
        snap_strobe = 1'b0;
        wait_transfers(target, 4 * N, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL pattern_transfer sweep=%h got %0d transfers expected %0d", sw, transfers, target);
        end
    endtask

    task automatic test_ignored_strobes();
        logic [N*N-1:0]       base;
        int                   e;
        int                   m;
        int                   pulses;
        int                   xfer0;
        logic [SW-1:0]        hold_sweep;
        logic signed [EW-1:0] hold_energy;
        logic signed [MW-1:0] hold_mag;
        out_ready = 1'b0;
        base      = rand_lattice();
        model(base, e, m);
        drive_strobe(base, 32'hCAFE_0004, e, m);
        step();
        snap_strobe = 1'b0;
        pulses      = 0;
        for (int c = 0; c < N - 2; c++) begin
            lattice     = rand_lattice();
            sweep_in    = $urandom;
            snap_strobe = ((c % 6) == 2) && (pulses < 5);
            if (snap_strobe) pulses++;
            step();
        end
        snap_strobe = 1'b0;
        for (int t = 0; t < 4 * N && !out_valid; t++) step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_valid got %b expected 1", out_valid);
        end
        hold_sweep  = out_sweep;
        hold_energy = out_energy;
        hold_mag    = out_mag;
        for (int c = 0; c < 10; c++) begin
            lattice = rand_lattice();
            step();
            checks++;
            if (out_valid !== 1'b1 || out_energy !== hold_energy || out_mag !== hold_mag || out_sweep !== hold_sweep) begin
                errors++;
                $display("[TB] FAIL stall_stable cycle %0d got valid=%b energy=%0d mag=%0d sweep=%h, expected valid=1 energy=%0d mag=%0d sweep=%h",
                         c, out_valid, out_energy, out_mag, out_sweep, hold_energy, hold_mag, hold_sweep);
            end
        end
`ifdef ISING_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd5) begin
            errors++;
            $display("[TB] FAIL drop_cnt_busy got %0d expected 5", drop_cnt);
        end
`endif
        xfer0       = transfers;
        out_ready   = 1'b1;
        snap_strobe = 1'b1;
        step();
        snap_strobe = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || transfers != xfer0 + 1) begin
            errors++;
            $display("[TB] FAIL handshake got busy=%b valid=%b transfers=%0d, expected busy=0 valid=0 transfers=%0d",
                     busy, out_valid, transfers, xfer0 + 1);
        end
        repeat (3) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL handshake_strobe_ignored got busy=%b expected 0", busy);
        end
`ifdef ISING_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd6) begin
            errors++;
            $display("[TB] FAIL drop_cnt_handshake got %0d expected 6", drop_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_accum();
        logic [N*N-1:0] lat;
        int             e;
        int             m;
        int             xfer0;
        bit             ok;
        out_ready = 1'b1;
        lat       = rand_lattice();
        model(lat, e, m);
        drive_strobe(lat, 32'hDEAD_0005, e, m);
        step();
        snap_strobe = 1'b0;
        repeat (16) step();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_accum got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
        end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abort got busy=%b valid=%b expected busy=0 valid=0", busy, out_valid);
        end
        reset = 1'b0;
        sb.delete();
        xfer0 = transfers;
        repeat (3) step();
        checks++;
        if (transfers != xfer0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dropped_record got transfers=%0d busy=%b expected transfers=%0d busy=0",
                     transfers, busy, xfer0);
        end
        lat = rand_lattice();
        model(lat, e, m);
        drive_strobe(lat, 32'hBEEF_0006, e, m);
        step();
        snap_strobe = 1'b0;
        wait_transfers(xfer0 + 1, 4 * N, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL after_reset_transfer got %0d transfers expected %0d", transfers, xfer0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [N*N-1:0] lat;
        int             e;
        int             m;
        int             strobes;
        int             idle_s;
        int             s;
        int             xfer0;
        bit             prev_v;
        bit             done;
        out_ready = 1'b1;
        xfer0     = transfers;
        idle_s    = -1;
        s         = 0;
        prev_v    = 1'b0;
        done      = 1'b0;
        lat       = rand_lattice();
        model(lat, e, m);
        drive_strobe(lat, 32'h0000_0B00, e, m);
        strobes = 1;
        for (int t = 0; t < 6 * N && !done; t++) begin
            step();
            s++;
            snap_strobe = 1'b0;
            if (out_valid && !prev_v && idle_s >= 0) begin
                checks++;
                if (s - idle_s != N + 1) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing got %0d cycles from transfer to valid, expected %0d",
                             s - idle_s, N + 1);
                end
            end
            prev_v = out_valid;
            if (!busy) begin
                if (strobes < 3) begin
                    idle_s = s;
                    lat    = rand_lattice();
                    model(lat, e, m);
                    drive_strobe(lat, 32'h0000_0B00 + SW'(strobes), e, m);
                    strobes++;
                end else begin
                    done = 1'b1;
                end
            end
        end
        checks++;
        if (!done || transfers != xfer0 + 3 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_count got done=%b transfers=%0d pending=%0d, expected done=1 transfers=%0d pending=0",
                     done, transfers - xfer0, sb.size(), 3);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout with %0d transfers", transfers);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N*N-1:0] single;
        clk         = 1'b0;
        reset       = 1'b1;
        snap_strobe = 1'b0;
        lattice     = '0;
        sweep_in    = '0;
        out_ready   = 1'b0;
        checks      = 0;
        errors      = 0;
        transfers   = 0;
        single      = '0;
        single[0]   = 1'b1;
        #1;
        test_reset();
        test_all_ones();
        test_pattern(checker_lattice(), 32'h1234_0002, 4096, 0);
        test_pattern(single, 32'h1234_0003, -4080, -1022);
        test_ignored_strobes();
        test_reset_mid_accum();
        test_back_to_back();
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
